// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter family.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package rr_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Widest requester vector the index helper accepts.
    localparam int MAX_N = 64;

    // Width of a counter that must hold values 0..quantum; never below 1 bit.
    function automatic int cnt_width(input int quantum);
        int w;
        w = $clog2(quantum + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // One-hot to binary index; an all-zero input yields 0.
    function automatic int unsigned onehot_to_idx(input logic [MAX_N-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAX_N; i++) begin
            if (oh[i]) begin
                idx = idx | unsigned'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_param_pick.sv
// Round-robin pick: first set req bit searching circularly from ptr+1, ptr last.
// Latency: purely combinational.
// Backpressure: none; ports: req[N], ptr[IDW] in; onehot[N], any out.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   onehot,
    output logic           any
);

    int          sh;
    logic [N-1:0] rot;
    logic [N-1:0] rot_oh;

    // Rotate so that requester ptr+1 lands on bit 0, take the lowest set bit,
    // then rotate the winner back into requester numbering.
    always_comb begin
        sh = (int'(ptr) >= N - 1) ? 0 : int'(ptr) + 1;
        rot = '0;
        for (int i = 0; i < N; i++) begin
            rot[i] = req[(i + sh) % N];
        end
        rot_oh = rot & (~rot + N'(1));
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            onehot[(i + sh) % N] = rot_oh[i];
        end
        any = |req;
    end

endmodule

// File: rtl/rr_arbiter_param.sv
// Round-robin arbiter, N requesters, grant lock while owner requests, quantum-limited hold.
// Latency: req sampled at edge t, registered gnt/gnt_id/gnt_valid visible after that edge.
// Backpressure: none; owner drops req -> one trailing grant cycle. Ports: clk, rst_n, req[N] in; gnt[N], gnt_id[IDW], gnt_valid out.
module rr_arbiter_param
    import rr_arb_pkg::*;
#(
    parameter  int N       = 4,
    parameter  int QUANTUM = 4,
    localparam int IDW     = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_valid
);

    localparam int             CW       = cnt_width(QUANTUM);
    // Last hold_cnt value at which the owner may still keep the grant.
    localparam logic [CW-1:0]  HOLD_MAX = (QUANTUM == 0) ? '0 : CW'(QUANTUM - 1);

    arb_state_t     state;
    logic [IDW-1:0] ptr;       // in GRANT this is the current owner
    logic [CW-1:0]  hold_cnt;

    logic [N-1:0]   pick_oh;
    logic           pick_any;
    logic [IDW-1:0] pick_idx;
    logic           keep;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_oh),
        .any    (pick_any)
    );

    assign pick_idx = IDW'(onehot_to_idx(MAX_N'(pick_oh)));

    // Owner keeps the grant only while requesting and within its quantum.
    assign keep = req[ptr] && ((QUANTUM == 0) || (hold_cnt < HOLD_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= IDW'(N - 1);
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state     <= GRANT;
                        ptr       <= pick_idx;
                        hold_cnt  <= '0;
                        gnt       <= pick_oh;
                        gnt_id    <= pick_idx;
                        gnt_valid <= 1'b1;
                    end
                end
                GRANT: begin
                    if (keep) begin
                        // Saturate rather than wrap when the hold is unlimited.
                        if (hold_cnt != {CW{1'b1}}) begin
                            hold_cnt <= hold_cnt + CW'(1);
                        end
                    end else if (pick_any) begin
                        // Hand over (or re-grant the sole requester) with no idle gap.
                        ptr       <= pick_idx;
                        hold_cnt  <= '0;
                        gnt       <= pick_oh;
                        gnt_id    <= pick_idx;
                        gnt_valid <= 1'b1;
                    end else begin
                        // ptr keeps the last owner so it ranks lowest next time.
                        state     <= IDLE;
                        hold_cnt  <= '0;
                        gnt       <= '0;
                        gnt_id    <= '0;
                        gnt_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    hold_cnt  <= '0;
                    gnt       <= '0;
                    gnt_id    <= '0;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt))
        else $error("gnt has more than one bit set: %b", gnt);
    a_gnt_valid: assert property (@(posedge clk) disable iff (!rst_n) gnt_valid == (|gnt))
        else $error("gnt_valid inconsistent with gnt");
`endif

endmodule

// File: tb/tb_rr_arbiter_param.sv
// Bench for rr_arbiter_param (N=4, QUANTUM=4): directed scenarios plus random req,
// every cycle compared against a queue-free behavioural model of the arbitration rules.
// Reports one summary line.
module tb_rr_arbiter_param;

    localparam int N = 4;
    localparam int Q = 4;
    localparam int STARVE_BOUND = (N - 1) * Q + (N - 1);

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [1:0]   gnt_id;
    logic         gnt_valid;

    int n_tests;
    int n_fail;

    // Reference model state.
    bit m_busy;
    int m_owner;
    int m_last;
    int m_held;

    int wait0;
    int max_wait0;

    rr_arbiter_param #(.N(N), .QUANTUM(Q)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Circular search from last+1, last owner examined last.
    function automatic int next_owner(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy  = 0;
        m_owner = 0;
        m_last  = N - 1;
        m_held  = 0;
    endtask

    // m_held counts cycles the current owner has had the grant so far (1 = first cycle).
    task automatic model_step(input logic [N-1:0] r);
        int o;
        if (m_busy && r[m_owner] && m_held < Q) begin
            m_held++;
        end else begin
            if (m_busy) m_last = m_owner;
            o = next_owner(r, m_last);
            if (o < 0) begin
                m_busy = 0;
            end else begin
                m_busy  = 1;
                m_owner = o;
                m_last  = o;
                m_held  = 1;
            end
        end
    endtask

    function automatic logic [N-1:0] exp_gnt();
        return m_busy ? (N'(1) << m_owner) : '0;
    endfunction

    // Apply req for one cycle, advance the model and compare all outputs.
    task automatic cyc(input logic [N-1:0] r);
        req = r;
        @(posedge clk);
        #1;
        model_step(r);
        check("gnt", 32'(gnt), 32'(exp_gnt()));
        check("gnt_id", 32'(gnt_id), m_busy ? 32'(m_owner) : 32'd0);
        check("gnt_valid", 32'(gnt_valid), 32'(m_busy));
        if (r[0] && !gnt[0]) begin
            wait0++;
            if (wait0 > max_wait0) max_wait0 = wait0;
        end else begin
            wait0 = 0;
        end
    endtask

    initial begin
        logic [N-1:0] r;
        n_tests   = 0;
        n_fail    = 0;
        wait0     = 0;
        max_wait0 = 0;
        rst_n     = 1'b0;
        req       = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_gnt_id", 32'(gnt_id), 32'd0);
        check("rst_gnt_valid", 32'(gnt_valid), 32'd0);
        rst_n = 1'b1;

        // Scenarios 1 and 2: all requesting, quantum rotation 0,1,2,3,0.
        for (int i = 0; i < 17; i++) begin
            cyc(4'b1111);
            check("rot_id", 32'(gnt_id), 32'((i / Q) % N));
            check("rot_valid", 32'(gnt_valid), 32'd1);
        end

        // Reset asserted mid-cycle while a grant is held.
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_gnt", 32'(gnt), 32'd0);
        check("midrst_gnt_id", 32'(gnt_id), 32'd0);
        check("midrst_gnt_valid", 32'(gnt_valid), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(4'b1111);
        check("post_rst_first", 32'(gnt), 32'b0001);
        cyc(4'b0000);
        cyc(4'b0000);

        // Scenario 3: short request then idle.
        cyc(4'b0010);
        check("s3_g0", 32'(gnt), 32'b0010);
        cyc(4'b0010);
        check("s3_g1", 32'(gnt), 32'b0010);
        cyc(4'b0000);
        check("s3_idle", 32'(gnt_valid), 32'd0);

        // Scenario 4: sole requester 2 re-granted across quantum expiry.
        for (int i = 0; i < 10; i++) begin
            cyc(4'b0100);
            check("s4_hold", 32'(gnt), 32'b0100);
        end

        // Scenario 5: owner 3 with requester 0 also waiting.
        cyc(4'b1000);
        check("s5_own3", 32'(gnt), 32'b1000);
        repeat (3) cyc(4'b1001);
        check("s5_still3", 32'(gnt), 32'b1000);
        cyc(4'b1001);
        check("s5_wrap0", 32'(gnt), 32'b0001);
        repeat (3) cyc(4'b1001);
        cyc(4'b1001);
        check("s5_back3", 32'(gnt), 32'b1000);

        // Scenario 6: owner 1 drops with 1110 pending -> requester 2 next.
        cyc(4'b0010);
        check("s6_own1", 32'(gnt), 32'b0010);
        cyc(4'b1110);
        cyc(4'b1100);
        check("s6_next2", 32'(gnt), 32'b0100);

        // Random: requester 0 held continuously, others random.
        wait0 = 0;
        max_wait0 = 0;
        for (int i = 0; i < 6000; i++) begin
            r = N'($urandom);
            r[0] = 1'b1;
            cyc(r);
        end
        // Fully random, including sparse and idle patterns.
        for (int i = 0; i < 4000; i++) begin
            r = N'($urandom) & N'($urandom_range(0, 15));
            cyc(r);
        end
        check("starve_bound_ok", 32'(max_wait0 <= STARVE_BOUND), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
